// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: FSM states, requester ids and defaults
// shared by the UART TX arbiter and its bench
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARB     = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4
  } arb_state_t;

  localparam int REQ_LOOPBACK  = 0;
  localparam int REQ_STOPWATCH = 1;
  localparam int REQ_WATCH     = 2;
  localparam int REQ_TIMER     = 3;
  localparam int REQ_SR04      = 4;
  localparam int REQ_DHT11     = 5;

  localparam int TIMEOUT_CYC_DEF = 100000;

  // index + 1, wrapping at n rather than at a power of two
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester lanes plus the uart_tx side
// master = requesters/uart, slave = arbiter
interface uart_tx_arbiter_if #(
  parameter int N = 6
);

  logic [N-1:0]   req;
  logic [N-1:0]   byte_valid;
  logic [N*8-1:0] byte_data;
  logic [N-1:0]   byte_last;
  logic [N-1:0]   byte_ack;
  logic [N-1:0]   grant;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           arb_busy;
  logic           timeout;

  modport master (
    output req, byte_valid, byte_data,
    output byte_last, tx_busy,
    input  byte_ack, grant, tx_start,
    input  tx_data, arb_busy, timeout
  );

  modport slave (
    input  req, byte_valid, byte_data,
    input  byte_last, tx_busy,
    output byte_ack, grant, tx_start,
    output tx_data, arb_busy, timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// rr_picker: first set request at or after ptr,
// scanning circularly; one-hot pick plus its index
module rr_picker #(
  parameter int N  = 6,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] pick_idx,
  output logic          valid
);

  int            s;
  logic [PW-1:0] idx;

  // circular priority scan starting at ptr
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    s        = 0;
    idx      = '0;
    for (int k = 0; k < N; k++) begin
      s = int'(ptr) + k;
      if (s >= N) s = s - N;
      idx = PW'(s);
      if (!valid && req[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the UART TX channel,
// one message per grant. Optional stall release: UART_ARB_TIMEOUT_EN
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N           = 6,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic              clk,
  input logic              rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  arb_state_t    state;
  logic [N-1:0]  grant_q;
  logic [N-1:0]  ack_q;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] g_idx;
  logic          tx_start_q;
  logic [7:0]    tx_data_q;
  logic          last_q;
  logic          timeout_q;

  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic          pick_vld;
  logic [PW-1:0] nxt_ptr;
  logic          stall_hit;

  rr_picker #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .req      (bus.req),
    .ptr      (rr_ptr),
    .pick     (pick),
    .pick_idx (pick_idx),
    .valid    (pick_vld)
  );

  // the releasing owner becomes lowest priority
  assign nxt_ptr = PW'(wrap_inc(int'(g_idx), N));

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_t    state_d;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] stall_eff;
  logic          waiting;

  assign waiting = state inside
    {ST_LOAD, ST_WAIT_HI, ST_WAIT_LO};
  assign stall_eff = (state != state_d)
    ? '0 : stall_cnt;
  assign stall_hit = waiting &&
    (stall_eff == CW'(TIMEOUT_CYC - 1));

  // cycles spent in the current state, restarted on change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_d   <= ST_IDLE;
      stall_cnt <= '0;
    end else begin
      state_d   <= state;
      stall_cnt <= waiting ? stall_eff + 1'b1 : '0;
    end
  end
`else
  localparam int timeout_unused = TIMEOUT_CYC;

  assign stall_hit = 1'b0;
`endif

  // message FSM; grant, ack, start and data all registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant_q    <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      last_q     <= 1'b0;
      rr_ptr     <= '0;
      g_idx      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      timeout_q  <= 1'b0;
      if (stall_hit) begin
        grant_q   <= '0;
        timeout_q <= 1'b1;
        rr_ptr    <= nxt_ptr;
        state     <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (|bus.req) state <= ST_ARB;
          end
          ST_ARB: begin
            if (pick_vld) begin
              grant_q <= pick;
              g_idx   <= pick_idx;
              state   <= ST_LOAD;
            end else begin
              state   <= ST_IDLE;
            end
          end
          ST_LOAD: begin
            if (!bus.req[g_idx]) begin
              grant_q <= '0;
              rr_ptr  <= nxt_ptr;
              state   <= ST_IDLE;
            end else if (bus.byte_valid[g_idx] &&
                         !bus.tx_busy) begin
              tx_start_q <= 1'b1;
              ack_q      <= grant_q;
              tx_data_q  <=
                bus.byte_data[{g_idx, 3'b000} +: 8];
              last_q     <= bus.byte_last[g_idx];
              state      <= ST_WAIT_HI;
            end
          end
          ST_WAIT_HI: begin
            if (bus.tx_busy) state <= ST_WAIT_LO;
          end
          ST_WAIT_LO: begin
            if (!bus.tx_busy) begin
              if (last_q) begin
                grant_q <= '0;
                rr_ptr  <= nxt_ptr;
                state   <= ST_IDLE;
              end else begin
                state   <= ST_LOAD;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.grant    = grant_q;
  assign bus.byte_ack = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.arb_busy = (state != ST_IDLE);
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: randomized scoreboard bench; a
// message-level round-robin model predicts the UART byte stream
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 6;
  localparam int TO = 50;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } lane_t;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus();

  uart_tx_arbiter #(
    .N           (N),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  lane_t pend[N][$];
  lane_t lane_q[N][$];
  int    gap[N];
  bit    abort1[N];
  bit    stall[N];
  int    model_ptr = 0;
  bit    u_active = 1'b0;
  int    u_pend, u_blen;
  bit    timeout_seen = 1'b0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grant"}, 64'(bus.grant), 0);
    chk({tag, "_ack"}, 64'(bus.byte_ack), 0);
    chk({tag, "_start"}, 64'(bus.tx_start), 0);
    chk({tag, "_data"}, 64'(bus.tx_data), 0);
    chk({tag, "_busy"}, 64'(bus.arb_busy), 0);
    chk({tag, "_tmo"}, 64'(bus.timeout), 0);
  endtask

  task automatic clear_tb();
    for (int i = 0; i < N; i++) begin
      lane_q[i].delete();
      pend[i].delete();
      abort1[i] = 1'b0;
      stall[i]  = 1'b0;
      gap[i]    = 0;
    end
    u_active    = 1'b0;
    bus.tx_busy = 1'b0;
    exp_q.delete();
    model_ptr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_tb();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add_msg(input int i, input int len);
    lane_t b;
    for (int k = 0; k < len; k++) begin
      b.data = 8'($urandom);
      b.last = (k == len - 1);
      pend[i].push_back(b);
    end
  endtask

  // whole messages served round-robin from the pointer;
  // a requester keeps requesting while it has messages
  task automatic launch();
    lane_t b;
    int    j;
    bit    found;
    while (1) begin
      found = 1'b0;
      j = 0;
      for (int k = 0; k < N; k++) begin
        int c = (model_ptr + k) % N;
        if (!found && pend[c].size() > 0) begin
          found = 1'b1;
          j = c;
        end
      end
      if (!found) break;
      do begin
        b = pend[j].pop_front();
        lane_q[j].push_back(b);
        exp_q.push_back('{idx: j, data: b.data});
      end while (!b.last && pend[j].size() > 0);
      model_ptr = (j + 1) % N;
    end
    for (int i = 0; i < N; i++) gap[i] = $urandom_range(0, 2);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    bit busy;
    do begin
      @(negedge clk);
      n++;
      busy = bus.arb_busy || u_active;
      for (int i = 0; i < N; i++)
        if (lane_q[i].size() > 0) busy = 1'b1;
    end while (busy && n < 5000);
    chk({name, "_done"}, 64'(busy), 0);
    chk({name, "_drain"}, 64'(exp_q.size()), 0);
    chk({name, "_gnt0"}, 64'(bus.grant), 0);
  endtask

  // requester lanes
  initial begin
    bus.req        = '0;
    bus.byte_valid = '0;
    bus.byte_data  = '0;
    bus.byte_last  = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (bus.byte_ack[i] && lane_q[i].size() > 0) begin
          void'(lane_q[i].pop_front());
          gap[i] = $urandom_range(0, 2);
          if (abort1[i]) lane_q[i].delete();
        end
        if (stall[i]) begin
          bus.req[i]        = 1'b1;
          bus.byte_valid[i] = 1'b0;
        end else if (lane_q[i].size() > 0) begin
          bus.req[i] = 1'b1;
          if (gap[i] > 0) begin
            gap[i]--;
            bus.byte_valid[i] = 1'b0;
          end else begin
            bus.byte_valid[i]     = 1'b1;
            bus.byte_data[8*i+:8] = lane_q[i][0].data;
            bus.byte_last[i]      = lane_q[i][0].last;
          end
        end else begin
          bus.req[i]        = 1'b0;
          bus.byte_valid[i] = 1'b0;
          bus.byte_last[i]  = 1'b0;
        end
      end
    end
  end

  // uart_tx stand-in: busy rises 1..3 cycles after start
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        u_active    = 1'b0;
        bus.tx_busy = 1'b0;
      end else if (bus.tx_start) begin
        u_active = 1'b1;
        u_pend   = $urandom_range(0, 2);
        u_blen   = $urandom_range(1, 5);
      end else if (u_active) begin
        if (u_pend > 0) begin
          u_pend--;
        end else if (u_blen > 0) begin
          bus.tx_busy = 1'b1;
          u_blen--;
        end else begin
          bus.tx_busy = 1'b0;
          u_active    = 1'b0;
        end
      end
    end
  end

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.timeout) timeout_seen = 1'b1;
        if (bus.tx_start || |bus.byte_ack) begin
          chk("start_pulse", 64'(bus.tx_start), 1);
          chk("start_busy", 64'(bus.tx_busy), 0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h expected none",
                     bus.tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 64'(bus.tx_data), 64'(e.data));
            chk("grant", 64'(bus.grant), 64'(1) << e.idx);
            chk("ack", 64'(bus.byte_ack), 64'(1) << e.idx);
          end
        end
      end
    end
  end

  initial begin
    lane_t b;
    int    n;
    int    mask;
    clear_tb();
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // contention from pointer 0: 1 before 4
    add_msg(REQ_STOPWATCH, 3);
    add_msg(REQ_SR04, 3);
    launch();
    wait_idle("contend");

    // fairness with both kept busy: 0,3,0,3
    do_reset();
    add_msg(REQ_LOOPBACK, 2);
    add_msg(REQ_LOOPBACK, 1);
    add_msg(REQ_TIMER, 2);
    add_msg(REQ_TIMER, 3);
    launch();
    wait_idle("fair");

    // single requester 2: "123"
    for (int k = 0; k < 3; k++) begin
      b.data = 8'(8'h31 + k);
      b.last = (k == 2);
      pend[REQ_WATCH].push_back(b);
    end
    launch();
    wait_idle("single");

    // pointer now 3: requester 3 ahead of 0
    add_msg(REQ_LOOPBACK, 1);
    add_msg(REQ_TIMER, 1);
    launch();
    wait_idle("ptr3");

    for (int p = 0; p < 12; p++) begin
      mask = $urandom_range(1, (1 << N) - 1);
      for (int i = 0; i < N; i++)
        if (mask[i]) begin
          n = $urandom_range(1, 2);
          for (int m = 0; m < n; m++)
            add_msg(i, $urandom_range(1, 4));
        end
      launch();
      wait_idle("rand");
    end

    // abort: requester 5 leaves after 1 of 4 bytes
    do_reset();
    add_msg(REQ_DHT11, 4);
    abort1[REQ_DHT11] = 1'b1;
    launch();
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    wait_idle("abort");
    abort1[REQ_DHT11] = 1'b0;
    add_msg(REQ_LOOPBACK, 1);
    add_msg(REQ_DHT11, 1);
    launch();
    wait_idle("post_abort");

    // reset while waiting for busy to fall
    do_reset();
    add_msg(REQ_LOOPBACK, 3);
    launch();
    n = 0;
    while (!bus.tx_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_busy_seen", 64'(bus.tx_busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    clear_tb();
    @(negedge clk);
    check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    add_msg(REQ_LOOPBACK, 2);
    launch();
    n = 0;
    while (!bus.req[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.grant[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("regrant_lat", 64'(n), 2);
    wait_idle("after_rst");

`ifdef UART_ARB_TIMEOUT_EN
    // requester 2 never presents a byte
    do_reset();
    stall[REQ_WATCH] = 1'b1;
    add_msg(REQ_SR04, 2);
    launch();
    n = 0;
    while (!bus.grant[REQ_WATCH] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_grant2", 64'(bus.grant[REQ_WATCH]), 1);
    n = 0;
    while (!bus.timeout && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", 64'(n), TO);
    chk("tmo_gnt_clr", 64'(bus.grant), 0);
    stall[REQ_WATCH] = 1'b0;
    wait_idle("tmo_next");
`else
    chk("no_timeout", 64'(timeout_seen), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
